mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory with an RD_LAT-deep read-tag pipeline.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to requester 0.
//
// state | meaning
// IDLE  | no request seen last cycle
// OWN0  | requester 0 granted most recently
// OWN1  | requester 1 granted most recently
module mem_arbiter #(
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [3:0]        wea0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic [3:0]        wea1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wea,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

    state_t              state_q, state_d;
    logic                gnt0_w, gnt1_w;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [RD_LAT-1:0]   tag_vld_q;
    logic [RD_LAT-1:0]   tag_id_q;
    logic                rd_push;
    logic                tag_out_vld, tag_out_id;
    logic [31:0]         rdata0_q, rdata1_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                rr_ptr_w;
    // IDLE and OWN1 both favour requester 0; only OWN0 hands priority to requester 1
    assign rr_ptr_w = (state_q == S_OWN0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gnt0_w) begin
            state_d = S_OWN0;
        end else if (gnt1_w) begin
            state_d = S_OWN1;
        end else if (!req0 && !req1) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        gnt0_w = 1'b0;
        gnt1_w = 1'b0;
        if (!rst) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (req0 && req1) begin
                gnt0_w = ~rr_ptr_w;
                gnt1_w = rr_ptr_w;
            end else begin
                gnt0_w = req0;
                gnt1_w = req1;
            end
`else
            gnt0_w = req0;
            gnt1_w = req1 & ~req0;
`endif
        end
    end

    assign gnt0 = gnt0_w;
    assign gnt1 = gnt1_w;

    // Memory port: granted requester drives through; otherwise hold last issued address/data
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wea   = 4'b0000;
        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (gnt0_w) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_wea   = wea0;
        end else if (gnt1_w) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_wea   = wea1;
        end
    end

    assign addr_d  = mem_addr;
    assign wdata_d = mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt0_w || gnt1_w) begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rd_push = (gnt0_w || gnt1_w) && (mem_wea == 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= rd_push;
            tag_id_q[0]  <= gnt1_w;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign tag_out_vld = tag_vld_q[RD_LAT-1];
    assign tag_out_id  = tag_id_q[RD_LAT-1];
    assign rvalid0     = !rst && tag_out_vld && !tag_out_id;
    assign rvalid1     = !rst && tag_out_vld && tag_out_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) rdata0_q <= mem_rdata;
            if (rvalid1) rdata1_q <= mem_rdata;
        end
    end

    // Read data passes straight through on the pulse and is held afterwards
    assign rdata0 = rst ? 32'h0 : (rvalid0 ? mem_rdata : rdata0_q);
    assign rdata1 = rst ? 32'h0 : (rvalid1 ? mem_rdata : rdata1_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized two-requester traffic.
// Honours MEM_ARB_ROUND_ROBIN_EN in its reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W = 19;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [3:0]        wea0 = 4'h0, wea1 = 4'h0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]       wdata0 = 32'h0, wdata1 = 32'h0;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]       rdata0, rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wea;
    logic [31:0]       mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wea0(wea0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .wea1(wea1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(int a);
        if (a == 16) return 32'hDEADBEEF;
        return {8'(a), 8'hA5, 8'(a + 7), 8'h3C};
    endfunction

    // Device-side memory: read-first, data appears RD_LAT cycles after the address
    logic [31:0] dmem  [0:63];
    logic [31:0] rpipe [0:RD_LAT-1];
    bit          dmem_init = 1'b0;

    always @(posedge clk) begin
        if (!dmem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= init_val(i);
            dmem_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) dmem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rpipe[0] <= dmem[mem_addr[5:0]];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    typedef struct packed {
        logic              g0;
        logic              g1;
        logic [3:0]        wea;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              in_rst;
    } gexp_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        int          due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    // Reference model state
    logic [31:0]       ref_mem [0:63];
    logic              p_act   [0:1];
    logic [3:0]        p_wea   [0:1];
    logic [ADDR_W-1:0] p_addr  [0:1];
    logic [31:0]       p_wdata [0:1];
    int                last_win = -1;
    logic [ADDR_W-1:0] hold_addr  = '0;
    logic [31:0]       hold_wdata = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void set_req(int n, logic [3:0] w, int a, logic [31:0] d);
        p_act[n]   = 1'b1;
        p_wea[n]   = w;
        p_addr[n]  = ADDR_W'(a);
        p_wdata[n] = d;
    endfunction

    task automatic step(input logic do_rst);
        int    win;
        gexp_t e;
        @(posedge clk);
        #1;
        rst = do_rst;
        if (do_rst) begin
            p_act[0] = 1'b0;
            p_act[1] = 1'b0;
        end
        req0 = p_act[0]; wea0 = p_wea[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
        req1 = p_act[1]; wea1 = p_wea[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
        win = -1;
        if (do_rst) begin
            rq.delete();
            last_win   = -1;
            hold_addr  = '0;
            hold_wdata = 32'h0;
        end else if (p_act[0] && p_act[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win = (last_win == 0) ? 1 : 0;
`else
            win = 0;
`endif
        end else if (p_act[0]) begin
            win = 0;
        end else if (p_act[1]) begin
            win = 1;
        end else begin
            last_win = -1;
        end
        e.g0     = (win == 0);
        e.g1     = (win == 1);
        e.in_rst = do_rst;
        if (win >= 0) begin
            last_win   = win;
            e.wea      = p_wea[win];
            e.addr     = p_addr[win];
            e.wdata    = p_wdata[win];
            hold_addr  = p_addr[win];
            hold_wdata = p_wdata[win];
            if (p_wea[win] == 4'h0) begin
                rq.push_back('{id: (win == 1), data: ref_mem[p_addr[win][5:0]], due: cyc + RD_LAT});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (p_wea[win][b]) ref_mem[p_addr[win][5:0]][8*b +: 8] = p_wdata[win][8*b +: 8];
            end
            p_act[win] = 1'b0;
        end else begin
            e.wea   = 4'h0;
            e.addr  = hold_addr;
            e.wdata = hold_wdata;
        end
        gq.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    // Monitor: pops grant expectations every cycle, read expectations on rvalid
    logic [31:0] exp_rd0 = 32'h0, exp_rd1 = 32'h0;
    initial begin
        gexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (started) begin
                if (gq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL grant_queue: no expectation at cycle %0d", cyc);
                end else begin
                    e = gq.pop_front();
                    chk("gnt", {gnt1, gnt0}, {e.g1, e.g0});
                    chk("mem_wea", mem_wea, e.wea);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wdata", mem_wdata, e.wdata);
                    if (e.in_rst) begin
                        chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
                        exp_rd0 = 32'h0;
                        exp_rd1 = 32'h0;
                    end
                end
                if (rvalid0 || rvalid1) begin
                    if (rq.size() == 0) begin
                        chk("spurious_rvalid", {rvalid1, rvalid0}, 2'b00);
                    end else begin
                        r = rq.pop_front();
                        chk("rvalid_id", {rvalid1, rvalid0}, r.id ? 2'b10 : 2'b01);
                        chk("rd_latency", cyc, r.due);
                        chk(r.id ? "rdata1" : "rdata0", r.id ? rdata1 : rdata0, r.data);
                        if (r.id) exp_rd1 = r.data;
                        else      exp_rd0 = r.data;
                    end
                end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                    r = rq.pop_front();
                    chk("missing_rvalid", {rvalid1, rvalid0}, r.id ? 2'b10 : 2'b01);
                end
                chk("hold_rdata0", rdata0, exp_rd0);
                chk("hold_rdata1", rdata1, exp_rd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        for (int n = 0; n < 2; n++) begin
            p_act[n] = 1'b0; p_wea[n] = 4'h0; p_addr[n] = '0; p_wdata[n] = 32'h0;
        end

        step(1'b1); step(1'b1); step(1'b1);
        idle(1);

        // Single read of preloaded word
        set_req(0, 4'h0, 'h10, 32'h0);
        step(1'b0);
        idle(RD_LAT + 2);

        // Both requesters held high for four cycles
        for (int i = 0; i < 4; i++) begin
            if (!p_act[0]) set_req(0, 4'h0, 'h21 + i, 32'h0);
            if (!p_act[1]) set_req(1, 4'h0, 'h31 + i, 32'h0);
            step(1'b0);
        end
        idle(RD_LAT + 3);

        // Byte-lane write then read-back from requester 1
        set_req(1, 4'b0100, 'h20, 32'h00AB0000);
        step(1'b0);
        set_req(1, 4'h0, 'h20, 32'h0);
        step(1'b0);
        idle(RD_LAT + 2);

        // Back-to-back reads from mixed requesters
        set_req(0, 4'h0, 'h1, 32'h0); step(1'b0);
        set_req(1, 4'h0, 'h2, 32'h0); step(1'b0);
        set_req(0, 4'h0, 'h3, 32'h0); step(1'b0);
        idle(RD_LAT + 2);

        // Read then immediate write to same word, then read again
        set_req(0, 4'h0, 'h5, 32'h0);        step(1'b0);
        set_req(1, 4'hF, 'h5, 32'h12345678); step(1'b0);
        set_req(0, 4'h0, 'h5, 32'h0);        step(1'b0);
        idle(RD_LAT + 2);

        // Reset one cycle after a read grant
        set_req(0, 4'h0, 'h10, 32'h0);
        step(1'b0);
        step(1'b1); step(1'b1);
        set_req(1, 4'h0, 'h11, 32'h0);
        step(1'b0);
        idle(RD_LAT + 2);

        // Randomized traffic with occasional drops and resets
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p_act[n]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(n, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                                int'($urandom_range(0, 63)), $urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    p_act[n] = 1'b0;
                end
            end
            step($urandom_range(0, 149) == 0);
        end
        p_act[0] = 1'b0;
        p_act[1] = 1'b0;
        idle(RD_LAT + 3);
        @(posedge clk);
        #1;
        chk("drain_reads", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
